gbf_psum_su_accum: RTL
======================

// Module: gbf_psum_su_accum
// PURPOSE
//  Parametrised successor to the fixed su_adder: reduces ROW*COL PE psums into configurable spatial-unroll
//  groups, then read-modify-write accumulates the group sums into the psum GBF. Sits between the PE array
//  and the psum GBF. Adds runtime group size, a first-pass init mode, address wrap and RAW forwarding.
// PARAMETERS
//  ROW                    16   PE array rows
//  COL                    16   PE array cols; NUM_PE = ROW*COL
//  OUT_BITWIDTH           16   signed psum width per PE
//  ACC_BITWIDTH           32   signed accumulator width per lane
//  PSUM_GBF_DATA_BITWIDTH 512  GBF line width; LANES = PSUM_GBF_DATA_BITWIDTH/ACC_BITWIDTH (16)
//  PSUM_GBF_ADDR_BITWIDTH 5    GBF address width
//  BEAT_BITWIDTH          16   width of beat counter
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    synchronous, active-low reset
//  start          in   1                    latch config, IDLE->RUN
//  cfg_red_log2   in   4                    log2 group size G; legal MIN_RED=log2(NUM_PE/LANES)..log2(NUM_PE)
//  cfg_first_pass in   1                    1: write sums directly (init), no GBF read
//  cfg_addr_base  in   PSUM_GBF_ADDR_BITWIDTH  first GBF line
//  cfg_addr_bound in   PSUM_GBF_ADDR_BITWIDTH  lines before wrap (>=1)
//  cfg_num_beats  in   BEAT_BITWIDTH        beats to accept (>=1)
//  in_valid       in   1                    psum vector valid
//  in_ready       out  1                    accept; in_valid&in_ready = beat
//  in_psum        in   NUM_PE*OUT_BITWIDTH  PE p at bits [p*OUT_BITWIDTH +: OUT_BITWIDTH]
//  psum_gbf_r_en  out  1                    GBF read strobe
//  psum_gbf_r_addr out PSUM_GBF_ADDR_BITWIDTH
//  psum_gbf_r_data in  PSUM_GBF_DATA_BITWIDTH  valid 1 cycle after r_en; old data on same-addr write
//  psum_gbf_w_en  out  1                    GBF write strobe (registered)
//  psum_gbf_w_addr out PSUM_GBF_ADDR_BITWIDTH
//  psum_gbf_w_data out PSUM_GBF_DATA_BITWIDTH
//  busy           out  1                    state != IDLE
//  done           out  1                    1-cycle pulse at end of job
//  cfg_err        out  1                    sticky: start with illegal cfg; cleared by next legal start
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; all outputs 0; counters, pipe valids, fwd regs cleared.
//  FSM IDLE -start&legal-> RUN -last beat accepted-> DRAIN -pipe empty (2 cyc)-> DONE(1 cyc, done=1) -> IDLE.
//   start with illegal cfg (red_log2 out of range, bound==0, beats==0): stay IDLE, cfg_err=1. start ignored if busy.
//  in_ready = (state==RUN). No GBF backpressure; throughput 1 beat/cycle.
//  Reduce: G=2^red_log2; lane k = sign-ext sum of PEs k*G..k*G+G-1, k < NUM_PE/G; lanes >= NUM_PE/G = 0.
//  Beat cycle t: r_en=~first_pass, r_addr=addr_cnt (combinational); lane sums + addr + first registered (S1).
//  Cycle t+1: acc = S1 sum + (first ? 0 : old), old = fwd data else r_data; registered -> w_* valid at t+2.
//  Latency: beat to w_en = 2 cycles. Lanes add independently, ACC_BITWIDTH two's complement wrap.
//  Forwarding: old = current w_data if w_en & w_addr==S1 addr (distance 1); else last-written reg if its
//   addr==S1 addr and written at t (distance 2); distance-1 has priority. Covers addr_bound 1 and 2.
//  Address: addr_cnt=base at start; +1 per beat; after base+bound-1 wraps to base (arith mod 2^ADDR).
//  Beat counter: RUN->DRAIN on beat where count==num_beats-1.
//  reset mid-job: immediate IDLE, pending writes dropped, no done.
// CONFIGURATION
//  SU_ACCUM_SAT_EN defined: lane add saturates to [-2^(ACC-1), 2^(ACC-1)-1].
//  Undefined: lane add wraps modulo 2^ACC_BITWIDTH. Reduction tree never saturates (sized to not overflow).
// STRUCTURE
//  Package gbf_su_pkg: state enum (IDLE,RUN,DRAIN,DONE), NUM_PE, LANES, MIN_RED, lane slice helpers.
//  Sub-module su_reduce_tree: combinational grouped adder tree, NUM_PE x OUT -> LANES x ACC, sel=red_log2.
//  Top holds FSM, counters, S1/S2 regs, forwarding and accumulate/saturate.
// TESTING
//  1 first_pass=1, red_log2=4, base=0, bound=4, beats=4, all PE=1 -> w_en @t+2..t+5, addr 0..3,
//    each used lane=16, r_en never high, done 1 cycle after last write.
//  2 same cfg, first_pass=0, GBF preloaded 100/lane -> r_en per beat, each lane written 116.
//  3 bound=1, beats=3, first_pass=0, PE=1, red_log2=8, GBF=0 -> addr 0 written 256, 512, 768 (fwd).
//  4 bound=2, beats=5, base=30 -> addr sequence 30,31,30,31,30; distance-2 fwd gives correct totals.
//  5 PE=-1 vs +1 alternating, red_log2=5; lane sum 0; SAT_EN: GBF 0x7FFFFFFF + 32 stays 0x7FFFFFFF,
//    without: wraps to 0x8000001F.
//  6 start with red_log2=3 -> cfg_err=1, stays IDLE; reset low mid-RUN -> next cycle w_en=0, busy=0, no done.

Source files
------------

// File: rtl/gbf_su_pkg.sv
// rtl/gbf_su_pkg.sv - shared types and constants for the psum spatial-unroll accumulator
// Purpose: FSM state enum, default array geometry (NUM_PE, LANES, MIN_RED) and the lane slice helper.
// Ports: none (package).
package gbf_su_pkg;

   localparam int DEF_ROW     = 16;
   localparam int DEF_COL     = 16;
   localparam int DEF_ACC_W   = 32;
   localparam int DEF_DATA_W  = 512;
   localparam int NUM_PE      = DEF_ROW * DEF_COL;
   localparam int LANES       = DEF_DATA_W / DEF_ACC_W;
   localparam int MIN_RED     = $clog2(NUM_PE / LANES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // LSB position of lane/element `idx` in a packed vector of `width`-bit elements
   function automatic int lane_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/gbf_psum_su_accum_if.sv
// rtl/gbf_psum_su_accum_if.sv - PE-array psum stream plus psum GBF read/write port bundle
// Purpose: groups the psum input handshake and the GBF read/write strobes.
// Ports: in_valid/in_ready/in_psum (PE array -> accumulator),
//        r_en/r_addr/r_data and w_en/w_addr/w_data (accumulator <-> psum GBF).
// Modports: slave = accumulator side, master = PE array / GBF side.
interface gbf_psum_su_accum_if #(
   parameter int ROW                    = 16,
   parameter int COL                    = 16,
   parameter int OUT_BITWIDTH           = 16,
   parameter int PSUM_GBF_DATA_BITWIDTH = 512,
   parameter int PSUM_GBF_ADDR_BITWIDTH = 5
);
   logic                              in_valid;
   logic                              in_ready;
   logic [ROW*COL*OUT_BITWIDTH-1:0]   in_psum;
   logic                              r_en;
   logic [PSUM_GBF_ADDR_BITWIDTH-1:0] r_addr;
   logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data;
   logic                              w_en;
   logic [PSUM_GBF_ADDR_BITWIDTH-1:0] w_addr;
   logic [PSUM_GBF_DATA_BITWIDTH-1:0] w_data;

   modport slave (
      input  in_valid, in_psum, r_data,
      output in_ready, r_en, r_addr, w_en, w_addr, w_data
   );

   modport master (
      output in_valid, in_psum, r_data,
      input  in_ready, r_en, r_addr, w_en, w_addr, w_data
   );
endinterface

// File: rtl/su_reduce_tree.sv
// rtl/su_reduce_tree.sv - combinational grouped adder tree, N_PE psums -> N_LANES group sums
// Purpose: lane k = sign-extended sum of PEs k*2^sel .. k*2^sel+2^sel-1; lanes past N_PE>>sel read 0.
// Ports: psum (N_PE x OUT_W packed, PE p at [p*OUT_W +: OUT_W]), sel (log2 group size),
//        lane_sum (N_LANES x ACC_W packed).
module su_reduce_tree
   import gbf_su_pkg::*;
#(
   parameter int N_PE    = NUM_PE,
   parameter int OUT_W   = 16,
   parameter int ACC_W   = 32,
   parameter int N_LANES = LANES,
   parameter int RED_MIN = MIN_RED,
   parameter int SEL_W   = 4
)(
   input  logic [N_PE*OUT_W-1:0]    psum,
   input  logic [SEL_W-1:0]         sel,
   output logic [N_LANES*ACC_W-1:0] lane_sum
);
   localparam int LOG_PE = $clog2(N_PE);

   // Level l holds N_PE>>l partial sums of 2^l PEs each; ACC_W bits never overflow here.
   for (genvar l = 0; l <= LOG_PE; l++) begin : g_lvl
      logic [ACC_W-1:0] s [N_PE>>l];
      for (genvar i = 0; i < (N_PE >> l); i++) begin : g_node
         if (l == 0) begin : g_leaf
            assign s[i] = {{(ACC_W-OUT_W){psum[i*OUT_W+OUT_W-1]}}, psum[i*OUT_W +: OUT_W]};
         end else begin : g_add
            assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
         end
      end
   end

   // Per lane, the candidate from every group size it can take part in
   logic [ACC_W-1:0] cand [N_LANES][LOG_PE+1];

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      for (genvar r = 0; r <= LOG_PE; r++) begin : g_r
         if (r >= RED_MIN && k < (N_PE >> r)) begin : g_used
            assign cand[k][r] = g_lvl[r].s[k];
         end else begin : g_zero
            assign cand[k][r] = '0;
         end
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < N_LANES; k++) begin
         for (int r = 0; r <= LOG_PE; r++) begin
            if (int'(sel) == r) lane_sum[lane_lsb(k, ACC_W) +: ACC_W] = cand[k][r];
         end
      end
   end

endmodule

// File: rtl/gbf_psum_su_accum.sv
// rtl/gbf_psum_su_accum.sv - grouped psum reduction with read-modify-write accumulation into the psum GBF
// Purpose: reduce PE psums into 2^cfg_red_log2 groups, then add them onto GBF lines (or init them).
// Ports: clk, reset (sync active-low), start + cfg_* (latched at start), bus (slave: psum stream in,
//        GBF read/write out), busy, done (1-cycle pulse), cfg_err (sticky illegal-config flag).
// Option: SU_ACCUM_SAT_EN defined -> lane accumulate saturates; undefined -> wraps.
module gbf_psum_su_accum
   import gbf_su_pkg::*;
#(
   parameter int ROW                    = 16,
   parameter int COL                    = 16,
   parameter int OUT_BITWIDTH           = 16,
   parameter int ACC_BITWIDTH           = 32,
   parameter int PSUM_GBF_DATA_BITWIDTH = 512,
   parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
   parameter int BEAT_BITWIDTH          = 16
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [3:0]                        cfg_red_log2,
   input  logic                              cfg_first_pass,
   input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] cfg_addr_base,
   input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] cfg_addr_bound,
   input  logic [BEAT_BITWIDTH-1:0]          cfg_num_beats,
   gbf_psum_su_accum_if.slave                bus,
   output logic                              busy,
   output logic                              done,
   output logic                              cfg_err
);
   localparam int N_PE    = ROW * COL;
   localparam int N_LANES = PSUM_GBF_DATA_BITWIDTH / ACC_BITWIDTH;
   localparam int LOG_PE  = $clog2(N_PE);
   localparam logic [3:0] RED_LO = 4'($clog2(N_PE / N_LANES));
   localparam logic [3:0] RED_HI = 4'(LOG_PE);
   localparam int AW = PSUM_GBF_ADDR_BITWIDTH;
   localparam int DW = PSUM_GBF_DATA_BITWIDTH;

   state_t state, state_nx;

   logic          first_q, s1_valid, s1_first, lw_valid;
   logic [3:0]    red_q;
   logic [AW-1:0] base_q, last_q, addr_cnt, s1_addr, lw_addr;
   logic [BEAT_BITWIDTH-1:0] beats_last_q, beat_cnt;
   logic [DW-1:0] lane_sum, s1_sum, lw_data, old, acc;

   wire cfg_legal = (cfg_red_log2 >= RED_LO) && (cfg_red_log2 <= RED_HI) &&
                    (cfg_addr_bound != '0) && (cfg_num_beats != '0);
   wire start_ok  = (state == IDLE) && start && cfg_legal;
   wire start_bad = (state == IDLE) && start && !cfg_legal;
   wire beat      = bus.in_valid && bus.in_ready;
   wire last_beat = beat && (beat_cnt == beats_last_q);

   function automatic logic [ACC_BITWIDTH-1:0] lane_add(input logic [ACC_BITWIDTH-1:0] a,
                                                        input logic [ACC_BITWIDTH-1:0] b);
`ifdef SU_ACCUM_SAT_EN
      logic [ACC_BITWIDTH:0] wide;
      wide = {a[ACC_BITWIDTH-1], a} + {b[ACC_BITWIDTH-1], b};
      // Top two bits disagree only on signed overflow; clamp toward the true sign.
      if (wide[ACC_BITWIDTH] != wide[ACC_BITWIDTH-1])
         lane_add = wide[ACC_BITWIDTH] ? {1'b1, {(ACC_BITWIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
      else
         lane_add = wide[ACC_BITWIDTH-1:0];
`else
      lane_add = a + b;
`endif
   endfunction

   su_reduce_tree #(
      .N_PE    (N_PE),
      .OUT_W   (OUT_BITWIDTH),
      .ACC_W   (ACC_BITWIDTH),
      .N_LANES (N_LANES),
      .RED_MIN (int'(RED_LO)),
      .SEL_W   (4)
   ) u_tree (
      .psum     (bus.in_psum),
      .sel      (red_q),
      .lane_sum (lane_sum)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // DRAIN ends once S1 is empty; the final write is on the bus that same cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_ok) state_nx = RUN;
         RUN:     if (last_beat) state_nx = DRAIN;
         DRAIN:   if (!s1_valid) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      done         = (state == DONE);
      bus.in_ready = (state == RUN);
   end

   assign bus.r_en   = beat && !first_q;
   assign bus.r_addr = addr_cnt;

   // Old line value: the GBF read misses writes issued in the previous two cycles, so take
   // the in-flight write (distance 1) first, then the one committed last cycle (distance 2).
   always_comb begin
      old = bus.r_data;
      if (bus.w_en && bus.w_addr == s1_addr) old = bus.w_data;
      else if (lw_valid && lw_addr == s1_addr) old = lw_data;
      if (s1_first) old = '0;
      acc = '0;
      for (int k = 0; k < N_LANES; k++) begin
         acc[lane_lsb(k, ACC_BITWIDTH) +: ACC_BITWIDTH] =
            lane_add(s1_sum[lane_lsb(k, ACC_BITWIDTH) +: ACC_BITWIDTH],
                     old[lane_lsb(k, ACC_BITWIDTH) +: ACC_BITWIDTH]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         first_q      <= 1'b0;
         red_q        <= '0;
         base_q       <= '0;
         last_q       <= '0;
         beats_last_q <= '0;
         addr_cnt     <= '0;
         beat_cnt     <= '0;
         cfg_err      <= 1'b0;
         s1_valid     <= 1'b0;
         s1_first     <= 1'b0;
         s1_addr      <= '0;
         s1_sum       <= '0;
         bus.w_en     <= 1'b0;
         bus.w_addr   <= '0;
         bus.w_data   <= '0;
         lw_valid     <= 1'b0;
         lw_addr      <= '0;
         lw_data      <= '0;
      end else begin
         if (start_ok) begin
            first_q      <= cfg_first_pass;
            red_q        <= cfg_red_log2;
            base_q       <= cfg_addr_base;
            last_q       <= cfg_addr_base + cfg_addr_bound - 1'b1;
            beats_last_q <= cfg_num_beats - 1'b1;
            addr_cnt     <= cfg_addr_base;
            beat_cnt     <= '0;
         end else if (beat) begin
            addr_cnt <= (addr_cnt == last_q) ? base_q : addr_cnt + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
         end

         if (start_ok)       cfg_err <= 1'b0;
         else if (start_bad) cfg_err <= 1'b1;

         s1_valid <= beat;
         s1_first <= first_q;
         s1_addr  <= addr_cnt;
         s1_sum   <= lane_sum;

         bus.w_en   <= s1_valid;
         bus.w_addr <= s1_addr;
         bus.w_data <= acc;

         lw_valid <= bus.w_en;
         lw_addr  <= bus.w_addr;
         lw_data  <= bus.w_data;
      end
   end

endmodule
